// File: rtl/gpu_prim_loader.sv
// -----------------------------------------------------------------------------
// gpu_prim_loader
//   Sequencer between the GP0 command FIFO and the loaded-register bank. Pops
//   command words one per cycle, decodes polygon (0x20-0x3F), rectangle
//   (0x60-0x7F) and fill (0x02) commands, and emits per-word load strobes into
//   the register bank. When a full primitive is in the bank it is offered to the
//   rasterizer / fill engine with o_primValid / i_primAck.
//
//   Optional feature macro: GPU_QUAD_POLY_EN
//     defined   : quad polygons issue two triangles {v0,v1,v2} then {v3,v1,v2}
//     undefined : quad words are still popped (keeps FIFO aligned) but the 4th
//                 vertex words load nothing and only the first triangle issues
//
// Ports
//   i_clk, i_rst         clock, synchronous active-high reset
//   i_fifoEmpty/Data     show-ahead FIFO status and head word
//   o_readFifo           pop head word this cycle (o_validData mirrors it)
//   o_command            command byte latched from word 0
//   o_targetVertex       register bank vertex slot 0..2
//   o_load*              register bank load strobes, qualified by the pop
//   o_loadSizeParam      0=VAR 1=1x1 2=8x8 3=16x16
//   o_loadRectEdge,
//   o_isVertexLoadState  rectangle edge generation controls
//   o_primValid/Type     primitive ready (0=tri 1=rect 2=fill), held until ack
//   i_primAck            consumer accepted primitive
//   o_unsupported        pulses with the pop of an unhandled command word
// -----------------------------------------------------------------------------
module gpu_prim_loader (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fifoEmpty,
    input  logic [31:0] i_fifoData,
    output logic        o_readFifo,
    output logic        o_validData,
    output logic [7:0]  o_command,
    output logic [1:0]  o_targetVertex,
    output logic        o_loadVertices,
    output logic        o_loadUV,
    output logic        o_loadRGB,
    output logic        o_loadAllRGB,
    output logic        o_loadCoord1,
    output logic        o_loadSize,
    output logic [1:0]  o_loadSizeParam,
    output logic        o_loadRectEdge,
    output logic        o_isVertexLoadState,
    output logic        o_primValid,
    output logic [1:0]  o_primType,
    input  logic        i_primAck,
    output logic        o_unsupported
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_COLOR     = 3'd1;
    localparam logic [2:0] S_VERTEX    = 3'd2;
    localparam logic [2:0] S_UV        = 3'd3;
    localparam logic [2:0] S_SIZE      = 3'd4;
    localparam logic [2:0] S_FILL_XY   = 3'd5;
    localparam logic [2:0] S_FILL_SIZE = 3'd6;
    localparam logic [2:0] S_ISSUE     = 3'd7;

    localparam logic [1:0] T_TRI  = 2'd0;
    localparam logic [1:0] T_RECT = 2'd1;
    localparam logic [1:0] T_FILL = 2'd2;

    logic [2:0] r_state;
    logic [1:0] r_vtx;
    logic [7:0] r_command;
    logic [1:0] r_primType;
    logic       r_gouraud;
    logic       r_quad;
    logic       r_textured;
    logic [1:0] r_size;

    logic [2:0] w_nextState;
    logic [1:0] w_nextVtx;
    logic [2:0] w_advState;
    logic [1:0] w_advVtx;
    logic       w_pop;
    logic       w_mute;
    logic       w_isPolyState;
    logic [1:0] w_slot;
    logic [7:0] w_head;
    logic       w_hdPoly;
    logic       w_hdRect;
    logic       w_hdFill;
    logic       w_unused_data;

    assign w_head        = i_fifoData[31:24];
    assign w_unused_data = ^i_fifoData[23:0];
    assign w_hdPoly      = (w_head[7:5] == 3'b001);
    assign w_hdRect      = (w_head[7:5] == 3'b011);
    assign w_hdFill      = (w_head == 8'h02);

    // No pop while offering a primitive, nor in a reset cycle.
    assign w_pop = !i_rst && !i_fifoEmpty && (r_state != S_ISSUE);

    assign w_isPolyState = (r_primType == T_TRI);
    // The 4th vertex reuses slot 0 so the second triangle is {v3,v1,v2}.
    assign w_slot = (r_vtx == 2'd3) ? 2'd0 : r_vtx;

`ifdef GPU_QUAD_POLY_EN
    assign w_mute = 1'b0;
`else
    // 4th-vertex words are swallowed without touching the bank.
    assign w_mute = w_isPolyState && (r_vtx == 2'd3);
`endif

    // Polygon advance after the last word of a vertex (position or UV).
    always_comb begin
        w_advState = S_ISSUE;
        w_advVtx   = r_vtx;
        if (r_vtx < 2'd2) begin
            w_advVtx   = r_vtx + 2'd1;
            w_advState = r_gouraud ? S_COLOR : S_VERTEX;
        end else if (r_vtx == 2'd3) begin
`ifdef GPU_QUAD_POLY_EN
            w_advState = S_ISSUE;
`else
            w_advState = S_IDLE;
            w_advVtx   = 2'd0;
`endif
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextVtx   = r_vtx;
        case (r_state)
            S_IDLE: begin
                if (w_pop) begin
                    w_nextVtx = 2'd0;
                    if (w_hdPoly || w_hdRect) w_nextState = S_VERTEX;
                    else if (w_hdFill)        w_nextState = S_FILL_XY;
                end
            end
            S_COLOR: begin
                if (w_pop) w_nextState = S_VERTEX;
            end
            S_VERTEX: begin
                if (w_pop) begin
                    if (r_textured) begin
                        w_nextState = S_UV;
                    end else if (!w_isPolyState) begin
                        w_nextState = (r_size == 2'd0) ? S_SIZE : S_ISSUE;
                    end else begin
                        w_nextState = w_advState;
                        w_nextVtx   = w_advVtx;
                    end
                end
            end
            S_UV: begin
                if (w_pop) begin
                    if (!w_isPolyState) begin
                        w_nextState = (r_size == 2'd0) ? S_SIZE : S_ISSUE;
                    end else begin
                        w_nextState = w_advState;
                        w_nextVtx   = w_advVtx;
                    end
                end
            end
            S_SIZE:      if (w_pop) w_nextState = S_ISSUE;
            S_FILL_XY:   if (w_pop) w_nextState = S_FILL_SIZE;
            S_FILL_SIZE: if (w_pop) w_nextState = S_ISSUE;
            S_ISSUE: begin
                if (i_primAck) begin
                    if (w_isPolyState && r_quad && (r_vtx == 2'd2)) begin
                        w_nextVtx   = 2'd3;
                        w_nextState = r_gouraud ? S_COLOR : S_VERTEX;
                    end else begin
                        w_nextVtx   = 2'd0;
                        w_nextState = S_IDLE;
                    end
                end
            end
            default: begin
                w_nextState = S_IDLE;
                w_nextVtx   = 2'd0;
            end
        endcase
    end

    // Load strobes: decoded from state, all qualified by the pop.
    always_comb begin
        o_targetVertex      = 2'd0;
        o_loadVertices      = 1'b0;
        o_loadUV            = 1'b0;
        o_loadRGB           = 1'b0;
        o_loadAllRGB        = 1'b0;
        o_loadCoord1        = 1'b0;
        o_loadSize          = 1'b0;
        o_loadSizeParam     = 2'd0;
        o_loadRectEdge      = 1'b0;
        o_isVertexLoadState = 1'b0;
        o_unsupported       = 1'b0;
        if (w_isPolyState && (r_state != S_IDLE)) o_targetVertex = w_slot;
        if (w_pop) begin
            case (r_state)
                S_IDLE: begin
                    if (w_hdPoly) begin
                        o_loadRGB    = 1'b1;
                        o_loadAllRGB = !w_head[4];
                    end else if (w_hdRect || w_hdFill) begin
                        o_loadRGB    = 1'b1;
                        o_loadAllRGB = 1'b1;
                    end else begin
                        o_unsupported = 1'b1;
                    end
                end
                S_COLOR: o_loadRGB = !w_mute;
                S_VERTEX: begin
                    o_loadVertices = !w_mute;
                    // Fixed-size rects derive the far edge from the vertex word.
                    if (!w_isPolyState && (r_size != 2'd0)) begin
                        o_loadSize          = 1'b1;
                        o_loadSizeParam     = r_size;
                        o_loadRectEdge      = 1'b1;
                        o_isVertexLoadState = 1'b1;
                    end
                end
                S_UV: o_loadUV = !w_mute;
                S_SIZE: begin
                    o_loadSize     = 1'b1;
                    o_loadRectEdge = 1'b1;
                end
                S_FILL_XY:   o_loadCoord1 = 1'b1;
                S_FILL_SIZE: o_loadSize   = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_vtx      <= 2'd0;
            r_command  <= 8'h00;
            r_primType <= T_TRI;
            r_gouraud  <= 1'b0;
            r_quad     <= 1'b0;
            r_textured <= 1'b0;
            r_size     <= 2'd0;
        end else begin
            r_state <= w_nextState;
            r_vtx   <= w_nextVtx;
            if ((r_state == S_IDLE) && w_pop) begin
                r_command <= w_head;
                if (w_hdPoly || w_hdRect || w_hdFill) begin
                    r_primType <= w_hdPoly ? T_TRI : (w_hdRect ? T_RECT : T_FILL);
                    r_gouraud  <= w_head[4];
                    r_quad     <= w_head[3];
                    r_textured <= w_head[2] && !w_hdFill;
                    r_size     <= w_head[4:3];
                end
            end
        end
    end

    assign o_readFifo  = w_pop;
    assign o_validData = w_pop;
    assign o_command   = r_command;
    assign o_primValid = (r_state == S_ISSUE);
    assign o_primType  = r_primType;

endmodule

// File: doc/gpu_prim_loader.md
# gpu_prim_loader

Sequencer for the GPU primitive register file. It pops GP0 words from the command FIFO, decodes polygon, rectangle and fill commands, and drives one set of per-word load strobes (target vertex, vertex/UV/RGB/size/coord loads) into the loaded-register bank. Once the bank holds a complete primitive, it hands the primitive to the rasterizer or fill engine with a valid/ack handshake. It sits between the GP0 FIFO and the register bank, and replaces ad-hoc word counting in the parser.

## Interface
Parameters:
- none

Ports:
- i_clk  in  1  GPU clock
- i_rst  in  1  reset, synchronous, active-high
- i_fifoEmpty  in  1  command FIFO empty (show-ahead FIFO)
- i_fifoData  in  32  FIFO head word
- o_readFifo  out  1  pop head word this cycle
- o_validData  out  1  load strobe qualifier to register bank; equals o_readFifo
- o_command  out  8  latched command byte (i_fifoData[31:24] of word 0)
- o_targetVertex  out  2  vertex slot 0..2
- o_loadVertices, o_loadUV, o_loadRGB, o_loadAllRGB  out  1 each  register bank load strobes
- o_loadCoord1, o_loadSize  out  1 each  fill/rect load strobes
- o_loadSizeParam  out  2  SIZE_VAR=0, SIZE_1x1=1, SIZE_8x8=2, SIZE_16x16=3
- o_loadRectEdge, o_isVertexLoadState  out  1 each  rectangle edge generation
- o_primValid  out  1  primitive complete in bank
- o_primType  out  2  0=triangle, 1=rectangle, 2=fill
- i_primAck  in  1  consumer accepted primitive
- o_unsupported  out  1  one-cycle pulse, non-handled command word dropped

## Operation
- States: IDLE, COLOR, VERTEX, UV, SIZE, FILL_XY, FILL_SIZE, ISSUE.
- Word consumption: a state needing a word asserts o_readFifo = !i_fifoEmpty. All strobes are combinational from state and are qualified by o_readFifo. Nothing is popped in ISSUE.
- IDLE: head word pops.
  - 0x20–0x3F: polygon. Flags: gouraud=bit4, quad=bit3, textured=bit2. Word 0 loads slot 0 RGB, with o_loadAllRGB=!gouraud. vtx=0. Go to VERTEX.
  - 0x60–0x7F: rectangle. Size=bits4:3, textured=bit2. Word 0 loads RGB with o_loadAllRGB=1. Go to VERTEX.
  - 0x02: fill. RGB with o_loadAllRGB=1. Go to FILL_XY.
  - Any other value: o_unsupported pulses, stay IDLE.
  - o_command latches on every pop in IDLE.
- Polygon VERTEX: o_loadVertices, target=slot(vtx). Go to UV if textured, else advance.
- Polygon UV: o_loadUV, target=slot(vtx). Advance.
- Advance rule:
  - vtx<2: vtx++, then COLOR if gouraud, else VERTEX.
  - vtx==2: ISSUE (type 0).
  - vtx==3: ISSUE.
- Polygon COLOR: o_loadRGB to slot(vtx), o_loadAllRGB=0.
- slot(vtx) = vtx for vtx≤2. The 4th vertex (vtx=3) maps to slot 0, so the second triangle is {v3,v1,v2}.
- Rectangle VERTEX:
  - Loads slot 0.
  - If size≠VAR: also o_loadSize, o_loadSizeParam=size, o_loadRectEdge=1, o_isVertexLoadState=1.
  - Next: UV if textured, else SIZE if VAR, else ISSUE (type 1).
  - Rectangle UV loads slot 0.
- Rectangle SIZE: o_loadSize, param=VAR, o_loadRectEdge=1, o_isVertexLoadState=0. Go to ISSUE.
- FILL_XY: o_loadCoord1. FILL_SIZE: o_loadSize, param=VAR. Go to ISSUE (type 2).
- ISSUE: o_primValid=1, held with o_primType until i_primAck.
  - On ack, a quad with vtx==2: vtx=3, then COLOR if gouraud, else VERTEX.
  - Otherwise: IDLE.

## Timing
- Reset values: state=IDLE, vtx=0, o_command=0x00, o_primValid=0, o_primType=0, o_unsupported=0. All strobes are 0.
- Throughput: at most one word per cycle, with no bubble between words while FIFO is non-empty.
- FIFO empty in a word state: the FSM stalls in place, all strobes are 0, and state is unchanged.
- o_primValid rises the cycle after the last word pops.
- Ack: i_primAck is sampled only while o_primValid=1. It is accepted the same cycle, and o_primValid falls the next cycle. The next pop may occur in that next cycle.
- ack in the first ISSUE cycle: the minimum ISSUE occupancy is 1 cycle.
- Reset mid-primitive: returns to IDLE next edge. The partial primitive is discarded, and no pop occurs in the reset cycle.
- Triangle: 4 words (flat) to 9 words (gouraud+textured). Gouraud textured quad: 12 words and two ISSUEs.

## Configuration
- GPU_QUAD_POLY_EN defined: quad polygons behave as above (two ISSUEs).
- GPU_QUAD_POLY_EN undefined: quad commands still consume all their words, so the FIFO stays aligned. Only the first triangle is issued; the 4th-vertex words pop with all strobes 0.

## Test plan
- Flat triangle: 0x20 with colour 0x20112233, vertices (10,20), (30,40), (50,60) -> 4 pops. Word 0 has loadRGB+loadAllRGB. Vertex strobes hit targets 0,1,2. o_primValid=1, type 0, one cycle after the 4th pop.
- Gouraud textured quad 0x3C (12 words), ack both issues -> two o_primValid pulses. Second phase loads colour/vertex/UV into target 0. With GPU_QUAD_POLY_EN undefined: one pulse, 12 pops.
- Rect 16x16 0x78 at (100,50) -> word 1 asserts loadVertices, loadSize, param=3, loadRectEdge, isVertexLoadState=1, target 0. Issue type 1 after 2 pops.
- Variable textured rect 0x64: colour, XY, UV, size 0x00200040 -> SIZE word has loadSize, param=0, loadRectEdge=1, isVertexLoadState=0. Issue after 4 pops.
- Fill 0x02 with XY 0x00100020 and size 0x00080010 -> loadCoord1 on word 1, loadSize on word 2, type 2. Holding i_primAck=0 for 5 cycles keeps o_primValid=1 and o_readFifo=0.
- FIFO empty for 3 cycles mid-triangle, then i_rst mid-quad -> no strobes during the stall. Reset returns to IDLE; unknown command 0xE1 then pulses o_unsupported once.
